// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and parity helper.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_XFER,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    // Odd parity: the returned bit makes the total count of ones in byte+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
// Flops reset high so an idle (pulled-up) line never produces a spurious edge.
module ps2_sync (
    input  logic clk_i,
    input  logic resetn,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic s1;
    logic s2;
    logic s_prev;

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= async_i;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign sync_o = s2;
    assign fall_o = s_prev & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 device-clocked bits,
// acknowledge check and bus-idle wait, with an overall timeout from clock release.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 150000
) (
    input  logic       clk_i,
    input  logic       resetn,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe_o,
    output logic       kdata_oe_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t               state;
    logic [PS2_FRAME_BITS-1:0]   frame;
    logic [INH_W-1:0]            inh_cnt;
    logic [TO_W-1:0]             to_cnt;
    logic [TO_W-1:0]             to_next;
    logic [3:0]                  bitcnt;
    logic                        ack_err_pend;

    logic kclk_s;
    logic kclk_fall;
    logic kdata_s;
    logic kdata_fall_unused;

    ps2_sync u_sync_kclk (
        .clk_i   (clk_i),
        .resetn  (resetn),
        .async_i (kclk_i),
        .sync_o  (kclk_s),
        .fall_o  (kclk_fall)
    );

    ps2_sync u_sync_kdata (
        .clk_i   (clk_i),
        .resetn  (resetn),
        .async_i (kdata_i),
        .sync_o  (kdata_s),
        .fall_o  (kdata_fall_unused)
    );

    assign to_next = to_cnt + TO_W'(1);

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            frame        <= '0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            bitcnt       <= '0;
            ack_err_pend <= 1'b0;
            tx_ready_o   <= 1'b1;
            kclk_oe_o    <= 1'b0;
            kdata_oe_o   <= 1'b0;
            done_o       <= 1'b0;
            ack_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            ack_err_o <= 1'b0;
            timeout_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (tx_valid_i && tx_ready_o) begin
                        frame      <= {1'b1, odd_parity(tx_data_i), tx_data_i};
                        inh_cnt    <= INH_LOAD;
                        kclk_oe_o  <= 1'b1;
                        tx_ready_o <= 1'b0;
                        state      <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (inh_cnt == INH_W'(1)) begin
                        inh_cnt    <= '0;
                        kdata_oe_o <= 1'b1;
                        state      <= ST_REQ;
                    end else begin
                        inh_cnt <= inh_cnt - INH_W'(1);
                    end
                end

                ST_REQ: begin
                    kclk_oe_o <= 1'b0;
                    to_cnt    <= '0;
                    bitcnt    <= '0;
                    state     <= ST_XFER;
                end

                ST_XFER, ST_ACK, ST_WAIT_IDLE: begin
                    // Timeout wins over any edge arriving in the same cycle.
                    if (to_next == TO_LIMIT) begin
                        to_cnt     <= '0;
                        kclk_oe_o  <= 1'b0;
                        kdata_oe_o <= 1'b0;
                        done_o     <= 1'b1;
                        timeout_o  <= 1'b1;
                        tx_ready_o <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        to_cnt <= to_next;
                        if (state == ST_XFER) begin
                            if (kclk_fall) begin
                                kdata_oe_o <= ~frame[bitcnt];
                                bitcnt     <= bitcnt + 4'd1;
                                if (bitcnt == LAST_BIT) begin
                                    state <= ST_ACK;
                                end
                            end
                        end else if (state == ST_ACK) begin
                            if (kclk_fall) begin
                                ack_err_pend <= kdata_s;
                                state        <= ST_WAIT_IDLE;
                            end
                        end else begin
                            if (kclk_s && kdata_s) begin
                                to_cnt     <= '0;
                                done_o     <= 1'b1;
                                ack_err_o  <= ack_err_pend;
                                tx_ready_o <= 1'b1;
                                state      <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    kclk_oe_o  <= 1'b0;
                    kdata_oe_o <= 1'b0;
                    tx_ready_o <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the host and the
// sampled bits are compared with a frame computed from the byte by plain arithmetic.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 1000;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready_o;
    logic       kclk_oe_o;
    logic       kdata_oe_o;
    logic       done_o;
    logic       ack_err_o;
    logic       timeout_o;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       kclk_line;
    logic       kdata_line;

    int n_checks = 0;
    int n_fail   = 0;
    int spurious = 0;
    bit allow_done;

    assign kclk_line  = ~(kclk_oe_o | dev_clk_low);
    assign kdata_line = ~(kdata_oe_o | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk),
        .resetn     (resetn),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready_o),
        .kclk_i     (kclk_line),
        .kdata_i    (kdata_line),
        .kclk_oe_o  (kclk_oe_o),
        .kdata_oe_o (kdata_oe_o),
        .done_o     (done_o),
        .ack_err_o  (ack_err_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o && !allow_done) spurious++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Expected line levels in device sampling order: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic do_transfer(input logic [7:0] b, input bit ack, input bit silent,
                               input int rst_edge, input bit hold, input bit started);
        logic [10:0] exp_bits;
        int n, first, k;
        exp_bits = frame_model(b);
        if (!started) begin
            @(negedge clk);
            check_eq("ready_before", tx_ready_o, 1);
            tx_data  = b;
            tx_valid = 1'b1;
        end
        @(negedge clk);
        allow_done = 1'b0;
        if (hold) tx_data = 8'hAA;
        else      tx_valid = 1'b0;
        check_eq("ready_busy", tx_ready_o, 0);
        check_eq("done_quiet", done_o, 0);

        n = 0;
        first = 0;
        while (kclk_oe_o && n < INH + 10) begin
            n++;
            if (kdata_oe_o && first == 0) first = n;
            @(negedge clk);
        end
        check_eq("inhibit_len", n, INH + 1);
        check_eq("start_cycle", first, INH + 1);
        check_eq("start_held", kdata_oe_o, 1);

        if (silent) begin
            allow_done = 1'b1;
            k = 0;
            while (!done_o && k < TMO + 20) begin
                @(negedge clk);
                k++;
            end
            check_eq("timeout_cycle", k, TMO);
            check_eq("timeout_flag", timeout_o, 1);
            check_eq("timeout_ackerr", ack_err_o, 0);
            check_eq("timeout_release", {kclk_oe_o, kdata_oe_o}, 0);
            check_eq("timeout_ready", tx_ready_o, 1);
            @(negedge clk);
            allow_done = 1'b0;
            check_eq("timeout_pulse", {done_o, timeout_o}, 0);
            return;
        end

        wait_cyc(HALF);
        check_eq("bit0", kdata_line, exp_bits[0]);
        for (int e = 1; e <= 10; e++) begin
            dev_clk_low = 1'b1;
            wait_cyc(HALF);
            if (e == rst_edge) begin
                resetn = 1'b0;
                #1;
                check_eq("rst_release", {kclk_oe_o, kdata_oe_o}, 0);
                check_eq("rst_ready", tx_ready_o, 1);
                check_eq("rst_done", {done_o, ack_err_o, timeout_o}, 0);
                dev_clk_low = 1'b0;
                wait_cyc(3);
                resetn = 1'b1;
                wait_cyc(2);
                check_eq("rst_idle_ready", tx_ready_o, 1);
                return;
            end
            dev_clk_low = 1'b0;
            check_eq($sformatf("bit%0d", e), kdata_line, exp_bits[e]);
            wait_cyc(HALF);
        end

        if (ack) dev_data_low = 1'b1;
        wait_cyc(4);
        dev_clk_low = 1'b1;
        wait_cyc(HALF);
        dev_clk_low = 1'b0;
        allow_done = 1'b1;
        k = 0;
        while (!done_o && k < 4 * HALF) begin
            @(negedge clk);
            k++;
            if (k == HALF) dev_data_low = 1'b0;
        end
        if (ack) check_eq("done_after_idle", (k > HALF) ? 1 : 0, 1);
        check_eq("done_seen", done_o, 1);
        check_eq("ack_err", ack_err_o, ack ? 0 : 1);
        check_eq("no_timeout", timeout_o, 0);
        check_eq("ready_at_done", tx_ready_o, 1);
        check_eq("lines_free", {kclk_oe_o, kdata_oe_o}, 0);
        if (!hold) begin
            @(negedge clk);
            allow_done = 1'b0;
            check_eq("pulse_1cyc", {done_o, ack_err_o}, 0);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        allow_done   = 1'b0;
        wait_cyc(3);
        check_eq("reset_ready", tx_ready_o, 1);
        check_eq("reset_outs", {kclk_oe_o, kdata_oe_o, done_o, ack_err_o, timeout_o}, 0);
        resetn = 1'b1;
        wait_cyc(2);
        check_eq("post_reset_ready", tx_ready_o, 1);

        do_transfer(8'hED, 1, 0, 0, 0, 0);
        do_transfer(8'h00, 1, 0, 0, 0, 0);
        do_transfer(8'h3C, 0, 0, 0, 0, 0);
        do_transfer(8'h81, 0, 1, 0, 0, 0);
        do_transfer(8'h55, 1, 0, 4, 0, 0);
        do_transfer(8'hFF, 1, 0, 0, 0, 0);
        do_transfer(8'hED, 1, 0, 0, 1, 0);
        do_transfer(8'hAA, 1, 0, 0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            logic [7:0] rb;
            bit ra;
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            do_transfer(rb, ra, 0, 0, 0, 0);
        end

        check_eq("spurious_done", spurious, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends command bytes such as 0xED (set LEDs) or 0xFF (reset) to the keyboard over the shared open-drain kclk/kdata lines. It sits beside the existing PS/2 receiver in `riscv_unit` and is loaded by the core through the keyboard peripheral's register interface. The block runs the full host-request sequence: inhibit, start, data, odd parity, stop, then checks the device acknowledge.

## Interface
- `INHIBIT_CYCLES`, default 1000: clk_i cycles for which kclk is held low before the start bit (100 µs at 10 MHz).
- `TIMEOUT_CYCLES`, default 150000: maximum number of clk_i cycles from clock release to acknowledge (15 ms).
- `clk_i`  in  1  system clock. One clock domain only.
- `resetn`  in  1  reset, asynchronous, active-low.
- `tx_data_i`  in  8  command byte.
- `tx_valid_i`  in  1  request; the byte is accepted when `tx_valid_i & tx_ready_o`.
- `tx_ready_o`  out  1  high only in IDLE.
- `kclk_i`  in  1  raw PS/2 clock pin level (asynchronous).
- `kdata_i`  in  1  raw PS/2 data pin level (asynchronous).
- `kclk_oe_o`  out  1  1 = pull kclk low; 0 = release.
- `kdata_oe_o`  out  1  1 = pull kdata low; 0 = release.
- `done_o`  out  1  one-cycle pulse at the end of every accepted transfer, including error ends.
- `ack_err_o`  out  1  one-cycle pulse together with `done_o` when the device did not acknowledge.
- `timeout_o`  out  1  one-cycle pulse together with `done_o` when the transfer timed out.

## Operation
- `kclk_i` and `kdata_i` each pass through a 2-FF synchronizer. A falling edge `kfall` is detected as previous synchronized value = 1 and current = 0.
- States: IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE.
- **IDLE**
  - Both oe outputs are 0.
  - On handshake: latch the byte and form the 10-bit frame {stop=1, parity=~^byte, byte}. Load the inhibit counter and go to INHIBIT.
- **INHIBIT**
  - `kclk_oe_o`=1 for exactly `INHIBIT_CYCLES` cycles, then go to REQ.
- **REQ** (one cycle)
  - `kclk_oe_o`=1 and `kdata_oe_o`=1 (start bit 0).
  - Next state is XFER with `kclk_oe_o`=0. Start the timeout counter and clear the bit counter.
- **XFER**
  - On each `kfall`, drive `kdata_oe_o = ~frame[bitcnt]` and increment `bitcnt`.
  - Falling edges 1–8 carry data LSB first, edge 9 carries parity, edge 10 carries stop (line released).
  - After edge 10, go to ACK.
- **ACK**
  - On the next `kfall` (edge 11), sample synchronized kdata: 0 means acknowledged, 1 means `ack_err` is pending.
  - Go to WAIT_IDLE.
- **WAIT_IDLE**
  - Wait until synchronized kclk=1 and kdata=1.
  - Then pulse `done_o` (plus `ack_err_o` if pending) and go to IDLE.
- **Timeout**: in XFER, ACK or WAIT_IDLE, when the timeout counter reaches `TIMEOUT_CYCLES`:
  - Both oe outputs go to 0.
  - `done_o` and `timeout_o` pulse.
  - Next state is IDLE.
  - Timeout has priority over a simultaneous `kfall`.
- `tx_valid_i` while busy is ignored; the byte is not queued.
- A `kfall` seen in IDLE, INHIBIT or REQ is ignored. This is device-to-host traffic, which the receiver handles.

## Timing
- **Reset values**
  - `tx_ready_o`=1. All other outputs 0.
  - State IDLE; counters 0.
  - Lines are released immediately on `resetn` falling, including mid-transfer.
- **Handshake at cycle 0**
  - `tx_ready_o`=0 from cycle 1.
  - `kclk_oe_o`=1 from cycle 1 to cycle `INHIBIT_CYCLES`+1 inclusive.
  - `kdata_oe_o`=1 from cycle `INHIBIT_CYCLES`+1.
  - `kclk_oe_o`=0 from cycle `INHIBIT_CYCLES`+2.
- **Edge latency**: the `kdata_oe_o` update follows a pin falling edge by 3 clk_i cycles (2 synchronizer stages plus the edge register). This is far inside the ≥30 µs low phase.
- **Pulse timing**
  - `done_o`, `ack_err_o` and `timeout_o` are registered and high for exactly 1 cycle.
  - `tx_ready_o` returns to 1 on the same cycle as `done_o`.
- **Counter widths**
  - `$clog2(INHIBIT_CYCLES+1)` for the inhibit counter.
  - `$clog2(TIMEOUT_CYCLES+1)` for the timeout counter.
  - 4-bit `bitcnt`.
  - No wrap-around is possible.

## Structure
- `ps2_pkg`: state enum `ps2_tx_state_t`, the frame-length constant `PS2_FRAME_BITS`=10, and an odd-parity function. The receiver shares this package.
- Sub-module `ps2_sync`: 2-FF synchronizer plus falling-edge detector. Instantiate it once per line; the receiver reuses it.
- Tristate pads live in `riscv_unit`: drive 0 when oe=1, otherwise high-Z, with a pull-up.

## Test plan
- **Send 0xED.** Device model clocks with a 100 µs period after release and samples on rising edges; it pulls data low at edge 11.
  - Inhibit lasts exactly 1000 cycles.
  - Sampled bits: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done_o`=1, `ack_err_o`=0.
- **Send 0x00.**
  - Parity bit = 1, eight 0 data bits.
  - Single `done_o` pulse; ready high afterwards.
- **No acknowledge.** Device leaves data high at edge 11 → `done_o` and `ack_err_o` pulse together, `timeout_o`=0.
- **Silent device.** Device never clocks → `timeout_o` and `done_o` pulse exactly `TIMEOUT_CYCLES` cycles after clock release; both lines released.
- **Reset mid-transfer.** Deassert `resetn` after falling edge 4 → oe outputs 0 immediately, `tx_ready_o`=1; a new 0xFF transfer then completes correctly.
- **Request while busy.** Hold `tx_valid_i` with 0xAA during an 0xED transfer → only 0xED appears on the line. 0xAA is accepted only after `done_o`, when ready returns to 1.
